// File: rtl/prio_evt_pkg.sv
// Shared types and event codes for the priority event capture block.
package prio_evt_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  localparam logic [1:0] CODE_A = 2'd2;
  localparam logic [1:0] CODE_B = 2'd1;
  localparam logic [1:0] CODE_C = 2'd0;

endpackage

// File: rtl/evt_sync.sv
// One-bit synchronizer with rising-edge event output.
// Build macro PRIO_EVT_DEBOUNCE_EN adds a stable-high debounce counter ahead of the event.
module evt_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_evt
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DB_CYCLES < 1 || DB_CYCLES > 255) begin : g_bad_cfg
    $error("evt_sync: SYNC_STAGES or DB_CYCLES out of range");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
  end

  assign w_lvl = r_sync[SYNC_STAGES-1];

`ifdef PRIO_EVT_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES);
  localparam logic [CW-1:0] DB_M1  = CW'(DB_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_evt;

  // Counter saturates at DB_MAX so the event fires once per high period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_evt <= 1'b0;
    end else begin
      r_evt <= w_lvl && (r_cnt == DB_M1);
      if (!w_lvl)               r_cnt <= '0;
      else if (r_cnt != DB_MAX) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_evt = r_evt;
`else
  logic r_prev;

  // History resets low, so a level held high through reset yields one event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= 1'b0;
    else        r_prev <= w_lvl;
  end

  assign o_evt = w_lvl & ~r_prev;
`endif

endmodule

// File: rtl/prio_evt_capture.sv
// Prioritised capture of three async events (a > b > c) plus a data path, into one q/q_vld output.
// Build macro PRIO_EVT_DEBOUNCE_EN enables input debounce in evt_sync.
module prio_evt_capture
  import prio_evt_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_a,
  input  logic       set_b,
  input  logic       set_c,
  input  logic [1:0] d,
  input  logic       d_vld,
  output logic       d_rdy,
  output logic [1:0] q,
  output logic       q_vld,
  input  logic       q_rdy,
  output logic       busy
);

  // Bit 2 = a, bit 1 = b, bit 0 = c.
  logic [2:0] w_evt;
  logic [2:0] w_req;
  logic [2:0] r_pend;
  logic [2:0] w_pend_nxt;
  logic [1:0] r_q;
  logic [1:0] w_q_nxt;
  logic       w_d_rdy;
  state_t     r_state;
  state_t     w_state_nxt;

  evt_sync #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_sync_a (
    .clk(clk), .rst_n(rst_n), .i_async(set_a), .o_evt(w_evt[2])
  );
  evt_sync #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_sync_b (
    .clk(clk), .rst_n(rst_n), .i_async(set_b), .o_evt(w_evt[1])
  );
  evt_sync #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_sync_c (
    .clk(clk), .rst_n(rst_n), .i_async(set_c), .o_evt(w_evt[0])
  );

  assign w_req = w_evt | r_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_q     <= 2'd0;
      r_pend  <= 3'b000;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_pend_nxt  = r_pend;
    w_d_rdy     = 1'b0;
    case (r_state)
      IDLE: begin
        // Losing simultaneous sources stay in r_pend for later service.
        if (w_req[2]) begin
          w_q_nxt     = CODE_A;
          w_pend_nxt  = w_req & 3'b011;
          w_state_nxt = PEND;
        end else if (w_req[1]) begin
          w_q_nxt     = CODE_B;
          w_pend_nxt  = w_req & 3'b001;
          w_state_nxt = PEND;
        end else if (w_req[0]) begin
          w_q_nxt     = CODE_C;
          w_pend_nxt  = 3'b000;
          w_state_nxt = PEND;
        end else begin
          w_d_rdy = 1'b1;
          if (d_vld) begin
            w_q_nxt     = d;
            w_state_nxt = PEND;
          end
        end
      end
      PEND: begin
        w_pend_nxt = r_pend | w_evt;
        if (q_rdy) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign d_rdy = w_d_rdy;
  assign q     = r_q;
  assign q_vld = (r_state == PEND);
  assign busy  = (r_state == PEND) || (|r_pend);

endmodule

// File: tb/tb_prio_evt_capture.sv
// Directed self-checking bench for prio_evt_capture (default and PRIO_EVT_DEBOUNCE_EN builds).
module tb_prio_evt_capture;

  localparam int SYNC_STAGES = 2;
  localparam int DB_CYCLES   = 4;
`ifdef PRIO_EVT_DEBOUNCE_EN
  localparam int LAT = SYNC_STAGES + DB_CYCLES + 1;
  localparam int PW  = DB_CYCLES;
`else
  localparam int LAT = SYNC_STAGES + 1;
  localparam int PW  = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       set_a, set_b, set_c;
  logic [1:0] d;
  logic       d_vld;
  logic       d_rdy;
  logic [1:0] q;
  logic       q_vld;
  logic       q_rdy;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  prio_evt_capture #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .set_a(set_a), .set_b(set_b), .set_c(set_c),
    .d(d), .d_vld(d_vld), .d_rdy(d_rdy), .q(q), .q_vld(q_vld), .q_rdy(q_rdy), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    n_tests++; if (q !== 2'd0) begin n_fail++; $display("FAIL reset_q got=%0d exp=0", q); end
    n_tests++; if (q_vld !== 1'b0) begin n_fail++; $display("FAIL reset_q_vld got=%b exp=0", q_vld); end
    n_tests++; if (d_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_d_rdy got=%b exp=1", d_rdy); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    step(2);
    rst_n = 1'b1;
    step(3);
    n_tests++; if (q_vld !== 1'b0 || d_rdy !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_idle q_vld=%b d_rdy=%b exp 0/1", q_vld, d_rdy);
    end
  endtask

  task automatic test_single_a;
    q_rdy = 1'b1;
    set_a = 1'b1;
    for (int cyc = 1; cyc <= LAT + 2; cyc++) begin
      step();
      if (cyc == PW) set_a = 1'b0;
      n_tests++; if (q_vld !== (cyc == LAT)) begin
        n_fail++; $display("FAIL single_a_vld cyc=%0d got=%b exp=%b", cyc, q_vld, (cyc == LAT));
      end
      if (cyc == LAT) begin
        n_tests++; if (q !== 2'd2) begin n_fail++; $display("FAIL single_a_q got=%0d exp=2", q); end
      end
    end
    set_a = 1'b0;
    step(LAT + 2);
  endtask

  task automatic test_simultaneous;
    logic [1:0] exp_q [3];
    exp_q[0] = 2'd2; exp_q[1] = 2'd1; exp_q[2] = 2'd0;
    q_rdy = 1'b1;
    set_a = 1'b1; set_b = 1'b1; set_c = 1'b1;
    step(LAT);
    for (int k = 0; k < 3; k++) begin
      n_tests++; if (q_vld !== 1'b1 || q !== exp_q[k]) begin
        n_fail++; $display("FAIL simul_out%0d q_vld=%b q=%0d exp 1/%0d", k, q_vld, q, exp_q[k]);
      end
      step();
      n_tests++; if (q_vld !== 1'b0) begin
        n_fail++; $display("FAIL simul_gap%0d q_vld=%b exp=0", k, q_vld);
      end
      n_tests++; if (busy !== (k < 2)) begin
        n_fail++; $display("FAIL simul_busy%0d got=%b exp=%b", k, busy, (k < 2));
      end
      step();
    end
    set_a = 1'b0; set_b = 1'b0; set_c = 1'b0;
    step(LAT + 2);
    n_tests++; if (q_vld !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL simul_quiet q_vld=%b busy=%b exp 0/0", q_vld, busy);
    end
  endtask

  task automatic test_data_hold;
    bit seen;
    q_rdy = 1'b0;
    d = 2'd3; d_vld = 1'b1;
    n_tests++; if (d_rdy !== 1'b1) begin n_fail++; $display("FAIL data_rdy_idle got=%b exp=1", d_rdy); end
    step();
    d_vld = 1'b0; d = 2'd0;
    set_b = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      n_tests++; if (q !== 2'd3 || q_vld !== 1'b1 || d_rdy !== 1'b0) begin
        n_fail++; $display("FAIL data_hold cyc=%0d q=%0d q_vld=%b d_rdy=%b exp 3/1/0", cyc, q, q_vld, d_rdy);
      end
      step();
    end
    q_rdy = 1'b1;
    step();
    n_tests++; if (q_vld !== 1'b0) begin n_fail++; $display("FAIL data_release got=%b exp=0", q_vld); end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (q_vld) seen = 1'b1;
      else step();
    end
    n_tests++; if (!seen || q !== 2'd1) begin
      n_fail++; $display("FAIL data_then_b seen=%b q=%0d exp 1/1", seen, q);
    end
    set_b = 1'b0;
    step(LAT + 2);
  endtask

  task automatic test_merge;
    int n_out;
    q_rdy = 1'b0;
    d = 2'd1; d_vld = 1'b1;
    step();
    d_vld = 1'b0; d = 2'd0;
    set_c = 1'b1; step(PW);
    set_c = 1'b0; step(PW);
    set_c = 1'b1; step(PW);
    set_c = 1'b0; step(LAT + 2);
    n_tests++; if (q !== 2'd1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL merge_hold q=%0d busy=%b exp 1/1", q, busy);
    end
    q_rdy = 1'b1;
    step();
    n_out = 0;
    for (int i = 0; i < 20; i++) begin
      if (q_vld) begin
        n_out++;
        n_tests++; if (q !== 2'd0) begin n_fail++; $display("FAIL merge_code got=%0d exp=0", q); end
      end
      step();
    end
    n_tests++; if (n_out !== 1) begin n_fail++; $display("FAIL merge_count got=%0d exp=1", n_out); end
  endtask

`ifdef PRIO_EVT_DEBOUNCE_EN
  task automatic test_debounce;
    int n_out;
    q_rdy = 1'b1;
    set_c = 1'b1; step(DB_CYCLES - 1);
    set_c = 1'b0;
    n_out = 0;
    for (int i = 0; i < 20; i++) begin
      if (q_vld) n_out++;
      step();
    end
    n_tests++; if (n_out !== 0) begin n_fail++; $display("FAIL db_short got=%0d exp=0", n_out); end
    set_c = 1'b1; step(DB_CYCLES);
    set_c = 1'b0;
    n_out = 0;
    for (int i = 0; i < 25; i++) begin
      if (q_vld) begin
        n_out++;
        n_tests++; if (q !== 2'd0) begin n_fail++; $display("FAIL db_code got=%0d exp=0", q); end
      end
      step();
    end
    n_tests++; if (n_out !== 1) begin n_fail++; $display("FAIL db_long got=%0d exp=1", n_out); end
  endtask
`else
  task automatic test_short_pulse;
    q_rdy = 1'b1;
    set_c = 1'b1; step();
    set_c = 1'b0;
    step(LAT - 1);
    n_tests++; if (q_vld !== 1'b1 || q !== 2'd0) begin
      n_fail++; $display("FAIL short_pulse q_vld=%b q=%0d exp 1/0", q_vld, q);
    end
    step(LAT + 2);
  endtask
`endif

  task automatic test_reset_in_pend;
    int n_out;
    q_rdy = 1'b0;
    set_a = 1'b1; set_b = 1'b1;
    step(LAT + 2);
    n_tests++; if (q !== 2'd2 || q_vld !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rst_pend_pre q=%0d q_vld=%b busy=%b exp 2/1/1", q, q_vld, busy);
    end
    set_a = 1'b0; set_b = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (q !== 2'd0 || q_vld !== 1'b0 || busy !== 1'b0 || d_rdy !== 1'b1) begin
      n_fail++; $display("FAIL rst_pend_async q=%0d q_vld=%b busy=%b d_rdy=%b exp 0/0/0/1", q, q_vld, busy, d_rdy);
    end
    step(2);
    rst_n = 1'b1;
    q_rdy = 1'b1;
    n_out = 0;
    for (int i = 0; i < 20; i++) begin
      if (q_vld) n_out++;
      step();
    end
    n_tests++; if (n_out !== 0) begin n_fail++; $display("FAIL rst_no_output got=%0d exp=0", n_out); end
    set_b = 1'b1;
    step(LAT + 3);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    n_out = 0;
    for (int i = 0; i < 20; i++) begin
      if (q_vld) begin
        n_out++;
        n_tests++; if (q !== 2'd1) begin n_fail++; $display("FAIL rst_held_code got=%0d exp=1", q); end
      end
      step();
    end
    n_tests++; if (n_out !== 1) begin n_fail++; $display("FAIL rst_held_count got=%0d exp=1", n_out); end
    set_b = 1'b0;
    step(LAT + 2);
  endtask

  initial begin
    rst_n = 1'b0;
    set_a = 1'b0; set_b = 1'b0; set_c = 1'b0;
    d = 2'd0; d_vld = 1'b0; q_rdy = 1'b0;
    test_reset();
    test_single_a();
    test_simultaneous();
    test_data_hold();
    test_merge();
`ifdef PRIO_EVT_DEBOUNCE_EN
    test_debounce();
`else
    test_short_pulse();
`endif
    test_reset_in_pend();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
